// File: rtl/rv_encode_pkg.sv
// RV32I encoding constants shared between the imem loader and the control decoder.
// Covers only the lw/sw/add/sub/slt/or/and/beq subset.
package rv_encode_pkg;

  typedef enum logic [2:0] {
    K_LW  = 3'd0,
    K_SW  = 3'd1,
    K_ADD = 3'd2,
    K_SUB = 3'd3,
    K_SLT = 3'd4,
    K_OR  = 3'd5,
    K_AND = 3'd6,
    K_BEQ = 3'd7
  } instr_kind_t;

  localparam logic [6:0] OPC_LW  = 7'b0000011;
  localparam logic [6:0] OPC_SW  = 7'b0100011;
  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_BEQ = 7'b1100011;

  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_BEQ = 3'b000;

  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_IS   = 2'd1;
  localparam logic [1:0] ERR_B    = 2'd2;

endpackage

// File: rtl/instr_field_packer.sv
// Combinational field packer: builds the 32-bit instruction word and flags
// immediates that the selected format cannot represent.
module instr_field_packer
  import rv_encode_pkg::*;
(
  input  instr_kind_t kind,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [12:0] imm,
  output logic [31:0] word,
  output logic [1:0]  imm_err
);

  always_comb begin
    word    = '0;
    imm_err = ERR_NONE;
    case (kind)
      K_LW: begin
        word = {imm[11:0], rs1, F3_LW, rd, OPC_LW};
        // 12-bit signed fits only when the 13-bit value is a sign extension of bit 11
        if (imm[12] != imm[11]) imm_err = ERR_IS;
      end
      K_SW: begin
        word = {imm[11:5], rs2, rs1, F3_SW, imm[4:0], OPC_SW};
        if (imm[12] != imm[11]) imm_err = ERR_IS;
      end
      K_ADD: word = {F7_ADD, rs2, rs1, F3_ADD, rd, OPC_R};
      K_SUB: word = {F7_SUB, rs2, rs1, F3_ADD, rd, OPC_R};
      K_SLT: word = {F7_ADD, rs2, rs1, F3_SLT, rd, OPC_R};
      K_OR:  word = {F7_ADD, rs2, rs1, F3_OR,  rd, OPC_R};
      K_AND: word = {F7_ADD, rs2, rs1, F3_AND, rd, OPC_R};
      K_BEQ: begin
        word = {imm[12], imm[10:5], rs2, rs1, F3_BEQ, imm[4:1], imm[11], OPC_BEQ};
        // 13 bits already bound the range; only an odd offset is unencodable
        if (imm[0]) imm_err = ERR_B;
      end
      default: word = '0;
    endcase
  end

endmodule

// File: rtl/imem_instr_loader.sv
// Sequential imem loader: accepts encode requests and writes packed words to
// consecutive word addresses, one registered write per accepted request.
//
//  state   | meaning
//  S_IDLE  | no session; waits for start
//  S_LOAD  | accepting requests while words written + in flight < DEPTH
//  S_FULL  | DEPTH words written; requests held off until finish
//  S_DRAIN | session closing; lets the last in-flight write complete
module imem_instr_loader
  import rv_encode_pkg::*;
#(
  parameter int                DEPTH     = 16,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  localparam int               CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              finish,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_kind,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rs1,
  input  logic [4:0]        req_rs2,
  input  logic [12:0]       req_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [CNT_W-1:0]  count,
  output logic              busy,
  output logic              err,
  output logic [1:0]        err_code
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FULL, S_DRAIN} state_t;

  localparam logic [CNT_W:0]   DEPTH_W  = (CNT_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

  state_t       state;
  logic [31:0]  enc_word;
  logic [1:0]   enc_err;
  logic [CNT_W:0] in_flight;
  logic         accept;

  instr_field_packer u_packer (
    .kind    (instr_kind_t'(req_kind)),
    .rd      (req_rd),
    .rs1     (req_rs1),
    .rs2     (req_rs2),
    .imm     (req_imm),
    .word    (enc_word),
    .imm_err (enc_err)
  );

  // A write on the bus this cycle has not yet been added to count
  assign in_flight = {1'b0, count} + {{CNT_W{1'b0}}, mem_we};
  assign req_ready = (state == S_LOAD) && (in_flight < DEPTH_W);
  assign accept    = req_valid && req_ready;
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      mem_we    <= 1'b0;
      mem_addr  <= BASE_ADDR;
      mem_wdata <= '0;
      count     <= '0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      mem_we <= 1'b0;
      if (mem_we) begin
        mem_addr <= mem_addr + ADDR_W'(4);
        count    <= count + CNT_W'(1);
      end
      if (accept) begin
        if (enc_err != ERR_NONE) begin
          err <= 1'b1;
          if (!err) err_code <= enc_err;
        end else begin
          mem_we    <= 1'b1;
          mem_wdata <= enc_word;
        end
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_LOAD;
            count    <= '0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
            mem_addr <= BASE_ADDR;
          end
        end
        S_LOAD: begin
          if (finish)                            state <= S_DRAIN;
          else if (mem_we && count == LAST_IDX)  state <= S_FULL;
        end
        S_FULL:  if (finish) state <= S_DRAIN;
        S_DRAIN: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
